fractal_colormap: RTL and testbench

- Downstream neighbour of the fractal generator: consumes its 8-bit iteration-count AXI4-Stream and emits 24-bit RGB AXI4-Stream toward the video DMA / VDMA path.
- Maps each count through a CPU-writable 256x24 palette RAM, or a grayscale bypass.
- Fixed 2-cycle pipeline with full backpressure.
- Forwards the frame-start (tuser) and line-end (tlast) sidebands aligned with the pixel data.

---
 rtl/fractal_pkg.sv | 26 ++
 rtl/fractal_palette_ram.sv | 30 +++
 rtl/fractal_colormap.sv | 132 +++++++++++++
 tb/tb_fractal_colormap.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// rtl/fractal_pkg.sv - shared constants, types and RGB packing for the fractal colour mapper
package fractal_pkg;

  localparam int IN_WIDTH_DEF   = 8;
  localparam int RGB_WIDTH_DEF  = 24;
  localparam int FCNT_WIDTH_DEF = 16;
  localparam int CH_WIDTH       = 8;

  localparam logic MODE_PALETTE = 1'b0;
  localparam logic MODE_GRAY    = 1'b1;

  typedef struct packed {
    logic user;
    logic last;
    logic mode;
  } side_t;

  function automatic logic [3*CH_WIDTH-1:0] pack_rgb(
    input logic [CH_WIDTH-1:0] r,
    input logic [CH_WIDTH-1:0] g,
    input logic [CH_WIDTH-1:0] b
  );
    return {r, g, b};
  endfunction

endpackage

// File: rtl/fractal_palette_ram.sv
// rtl/fractal_palette_ram.sv - simple dual-port palette RAM, read-first, registered read port
module fractal_palette_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Contents are deliberately not reset; the read register sees the pre-write entry.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fractal_colormap.sv
// rtl/fractal_colormap.sv - iteration-count stream to RGB stream via palette or grayscale, 2-cycle pipeline
module fractal_colormap
  import fractal_pkg::*;
#(
  parameter int IN_WIDTH   = IN_WIDTH_DEF,
  parameter int RGB_WIDTH  = RGB_WIDTH_DEF,
  parameter int FCNT_WIDTH = FCNT_WIDTH_DEF
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [IN_WIDTH-1:0]   s_axis_tdata,
  input  logic                  s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [RGB_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic                  pal_we,
  input  logic [IN_WIDTH-1:0]   pal_addr,
  input  logic [RGB_WIDTH-1:0]  pal_wdata,
  input  logic                  mode_req,
  output logic                  mode_active,
  output logic [FCNT_WIDTH-1:0] frame_count
);

  logic                  en;
  logic                  s_acc;
  logic                  beat_mode;
  logic [RGB_WIDTH-1:0]  ram_rdata;
  logic [CH_WIDTH-1:0]   gray_ch;
  logic [RGB_WIDTH-1:0]  gray_rgb;

  logic                  s1_valid_q, s1_valid_d;
  logic [IN_WIDTH-1:0]   s1_data_q,  s1_data_d;
  side_t                 s1_side_q,  s1_side_d;
  logic                  m_valid_q,  m_valid_d;
  logic [RGB_WIDTH-1:0]  m_data_q,   m_data_d;
  logic                  m_user_q,   m_user_d;
  logic                  m_last_q,   m_last_d;
  logic                  mode_q,     mode_d;
  logic [FCNT_WIDTH-1:0] fcnt_q,     fcnt_d;

  // Single global enable: the whole pipeline freezes while the output beat is held.
  assign en            = m_axis_tready | ~m_valid_q;
  assign s_acc         = s_axis_tvalid & en;
  assign s_axis_tready = en;

  fractal_palette_ram #(
    .ADDR_WIDTH (IN_WIDTH),
    .DATA_WIDTH (RGB_WIDTH)
  ) u_palette (
    .clk     (aclk),
    .wr_en   (pal_we),
    .wr_addr (pal_addr),
    .wr_data (pal_wdata),
    .rd_en   (en),
    .rd_addr (s_axis_tdata),
    .rd_data (ram_rdata)
  );

  assign gray_ch  = CH_WIDTH'(s1_data_q);
  assign gray_rgb = RGB_WIDTH'(pack_rgb(gray_ch, gray_ch, gray_ch));

  always_comb begin
    mode_d    = mode_q;
    beat_mode = mode_q;
    // A frame-start beat picks up the requested mode and carries it with itself.
    if (s_acc && s_axis_tuser) begin
      mode_d    = mode_req;
      beat_mode = mode_req;
    end

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_side_d  = s1_side_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    m_user_d   = m_user_q;
    m_last_d   = m_last_q;
    if (en) begin
      s1_valid_d     = s_axis_tvalid;
      s1_data_d      = s_axis_tdata;
      s1_side_d.user = s_axis_tuser;
      s1_side_d.last = s_axis_tlast;
      s1_side_d.mode = beat_mode;
      m_valid_d      = s1_valid_q;
      m_data_d       = (s1_side_q.mode == MODE_GRAY) ? gray_rgb : ram_rdata;
      m_user_d       = s1_side_q.user;
      m_last_d       = s1_side_q.last;
    end

    fcnt_d = fcnt_q;
    if (m_valid_q && m_axis_tready && m_user_q) begin
      fcnt_d = fcnt_q + FCNT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_side_q  <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_user_q   <= 1'b0;
      m_last_q   <= 1'b0;
      mode_q     <= MODE_PALETTE;
      fcnt_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_side_q  <= s1_side_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_user_q   <= m_user_d;
      m_last_q   <= m_last_d;
      mode_q     <= mode_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign mode_active   = mode_q;
  assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_fractal_colormap.sv
// tb/tb_fractal_colormap.sv - randomized and directed bench with a queue-based reference model
module tb_fractal_colormap;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tuser = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        pal_we = 1'b0;
  logic [7:0]  pal_addr = '0;
  logic [23:0] pal_wdata = '0;
  logic        mode_req = 1'b0;
  logic        mode_active;
  logic [15:0] frame_count;

  fractal_colormap dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_wdata     (pal_wdata),
    .mode_req      (mode_req),
    .mode_active   (mode_active),
    .frame_count   (frame_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [23:0] rgb;
    logic        user;
    logic        last;
    int          e;
  } beat_t;

  typedef struct {
    logic [23:0] d;
    logic        u;
    logic        l;
  } out_t;

  int          n_tests = 0;
  int          n_fail = 0;
  beat_t       exq[$];
  out_t        taken[$];
  logic [23:0] pal_m [256];
  logic        mode_m = 1'b0;
  logic [15:0] fc_m = '0;
  int          en_cnt = 0;
  logic        armed = 1'b0;
  logic        log_en = 1'b1;
  logic        exp_valid = 1'b0;
  int          rdy_mode = 0;
  int          pidx = 0;
  logic [3:0]  rdy_pat = 4'b1001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pinit(input logic [7:0] i);
    return {i, ~i, i ^ 8'h5A};
  endfunction

  // Reference model: every accepted beat is queued with its expected colour and the
  // number of enabled cycles seen so far; it must be on m_axis after two more.
  always @(negedge aclk) begin
    logic  exp_rdy;
    logic  en_m;
    logic  bm;
    beat_t b;
    out_t  o;
    exp_valid = (exq.size() > 0) && (en_cnt == exq[0].e + 2);
    exp_rdy   = m_axis_tready | ~exp_valid;
    if (armed) begin
      chk("m_tvalid", m_axis_tvalid, exp_valid);
      chk("s_tready", s_axis_tready, exp_rdy);
      chk("mode_active", mode_active, mode_m);
      chk("frame_count", frame_count, fc_m);
      if (exp_valid && m_axis_tvalid) begin
        chk("m_tdata", m_axis_tdata, exq[0].rgb);
        chk("m_tuser", m_axis_tuser, exq[0].user);
        chk("m_tlast", m_axis_tlast, exq[0].last);
      end
    end
    if (areset) begin
      exq.delete();
      mode_m = 1'b0;
      fc_m   = '0;
      armed  = 1'b1;
    end else if (armed) begin
      en_m = exp_rdy;
      if (exp_valid && m_axis_tready) begin
        if (exq[0].user) fc_m++;
        if (log_en) begin
          o.d = m_axis_tdata;
          o.u = m_axis_tuser;
          o.l = m_axis_tlast;
          taken.push_back(o);
        end
        void'(exq.pop_front());
      end
      if (s_axis_tvalid && en_m) begin
        bm = s_axis_tuser ? mode_req : mode_m;
        if (s_axis_tuser) mode_m = mode_req;
        b.rgb  = bm ? {3{s_axis_tdata}} : pal_m[s_axis_tdata];
        b.user = s_axis_tuser;
        b.last = s_axis_tlast;
        b.e    = en_cnt;
        exq.push_back(b);
      end
      if (en_m) en_cnt++;
    end
    if (pal_we) pal_m[pal_addr] = pal_wdata;
  end

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0: m_axis_tready = 1'b1;
      1: begin
        m_axis_tready = rdy_pat[pidx];
        pidx = (pidx + 1) % 4;
      end
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] d);
    pal_we = 1'b1;
    pal_addr = a;
    pal_wdata = d;
    cyc();
    pal_we = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic u, input logic l);
    int w;
    w = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tuser = u;
    s_axis_tlast = l;
    forever begin
      @(negedge aclk);
      if (s_axis_tready) break;
      w++;
      if (w > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: got no tready expected tready within 200 cycles");
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  initial begin
    logic acc;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h77;
    idle(3);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_fcnt", frame_count, 0);
    chk("rst_mode", mode_active, 0);
    areset = 1'b0;
    s_axis_tvalid = 1'b0;

    for (int i = 0; i < 256; i++) wr(8'(i), pinit(8'(i)));

    send(8'h20, 1'b1, 1'b0);
    chk("lat_stage1", m_axis_tvalid, 0);
    cyc();
    chk("lat_out_valid", m_axis_tvalid, 1);
    chk("lat_out_data", m_axis_tdata, 24'h20DF7A);
    idle(3);

    taken.delete();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(8'(i), i == 0, i == 7);
    idle(12);
    rdy_mode = 0;
    idle(2);
    chk("bp_count", taken.size(), 8);
    for (int i = 0; i < 8 && i < taken.size(); i++) begin
      chk("bp_data", taken[i].d, pinit(8'(i)));
      chk("bp_last", taken[i].l, i == 7);
    end

    wr(8'h05, 24'h123456);
    wr(8'hFF, 24'h000000);
    taken.delete();
    send(8'h05, 1'b1, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    idle(4);
    chk("pal_count", taken.size(), 2);
    chk("pal_05", taken[0].d, 24'h123456);
    chk("pal_ff", taken[1].d, 24'h000000);
    chk("pal_user", taken[0].u, 1);
    chk("pal_last", taken[1].l, 1);

    taken.delete();
    mode_req = 1'b0;
    send(8'h30, 1'b1, 1'b0);
    mode_req = 1'b1;
    send(8'h31, 1'b0, 1'b0);
    send(8'h32, 1'b0, 1'b1);
    idle(3);
    chk("mode_midframe", mode_active, 0);
    send(8'h40, 1'b1, 1'b0);
    send(8'h41, 1'b0, 1'b1);
    idle(4);
    chk("mode_count", taken.size(), 5);
    chk("mode_pal_tail", taken[1].d, 24'h31CE6B);
    chk("mode_gray_40", taken[3].d, 24'h404040);
    chk("mode_gray_41", taken[4].d, 24'h414141);
    chk("mode_active_gray", mode_active, 1);
    mode_req = 1'b0;
    send(8'h00, 1'b1, 1'b1);
    idle(4);
    chk("mode_back", mode_active, 0);

    wr(8'h10, 24'h111111);
    taken.delete();
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 8'h10;
    s_axis_tuser = 1'b0;
    s_axis_tlast = 1'b0;
    pal_we = 1'b1;
    pal_addr = 8'h10;
    pal_wdata = 24'hABCDEF;
    cyc();
    s_axis_tvalid = 1'b0;
    pal_we = 1'b0;
    send(8'h10, 1'b0, 1'b1);
    idle(4);
    chk("rdw_count", taken.size(), 2);
    chk("rdw_old", taken[0].d, 24'h111111);
    chk("rdw_new", taken[1].d, 24'hABCDEF);

    rdy_mode = 3;
    idle(2);
    taken.delete();
    send(8'h05, 1'b1, 1'b0);
    send(8'h06, 1'b0, 1'b0);
    chk("mfr_held", m_axis_tvalid, 1);
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    rdy_mode = 0;
    idle(6);
    chk("mfr_dropped", taken.size(), 0);
    chk("mfr_fcnt", frame_count, 0);
    send(8'h05, 1'b1, 1'b1);
    idle(4);
    chk("mfr_pal_kept", taken[0].d, 24'h123456);

    rdy_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      acc = s_axis_tvalid && s_axis_tready;
      @(posedge aclk);
      #1;
      if (!s_axis_tvalid || acc) begin
        s_axis_tvalid = 1'($urandom_range(0, 3) != 0);
        s_axis_tdata = 8'($urandom);
        s_axis_tuser = 1'($urandom_range(0, 15) == 0);
        s_axis_tlast = 1'($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 31) == 0) mode_req = ~mode_req;
      pal_we = 1'($urandom_range(0, 7) == 0);
      pal_addr = 8'($urandom);
      pal_wdata = 24'($urandom);
    end
    s_axis_tvalid = 1'b0;
    pal_we = 1'b0;
    mode_req = 1'b0;
    rdy_mode = 0;
    idle(10);
    chk("rand_drained", exq.size(), 0);

    log_en = 1'b0;
    areset = 1'b1;
    cyc();
    areset = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tuser = 1'b1;
    s_axis_tlast = 1'b1;
    s_axis_tdata = 8'h01;
    idle(65535);
    s_axis_tvalid = 1'b0;
    idle(4);
    chk("fcnt_ffff", frame_count, 16'hFFFF);
    send(8'h02, 1'b1, 1'b1);
    idle(4);
    chk("fcnt_wrap", frame_count, 16'h0000);
    chk("final_drained", exq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
